// File: rtl/vc_sched_pkg.sv
// vc_sched_pkg: shared types, default quanta and select padding for the VC plane scheduler
package vc_sched_pkg;
  localparam int WEIGHT_W_DEF = 4;
  typedef logic [WEIGHT_W_DEF-1:0] weight_t;
  localparam logic SEL_PAD = 1'b0;
  function automatic int unsigned default_weight(input int unsigned p, input int unsigned crit);
    return (p == 0) ? crit : 1;
  endfunction
endpackage

// File: rtl/vc_rr_search.sv
// vc_rr_search: rotating priority finder, first set bit of elig_i at or after start_i
module vc_rr_search #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Scan from the far end so the closest plane to start_i wins last
    for (int i = N - 1; i >= 0; i--) begin
      if (elig_i[(int'(start_i) + i) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(start_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/vc_plane_scheduler.sv
// vc_plane_scheduler: weighted rotating VC plane selector with shadowed run-time quanta
module vc_plane_scheduler
  import vc_sched_pkg::*;
#(
  parameter int VC          = 4,
  parameter int WEIGHT_W    = 4,
  parameter int CRIT_WEIGHT = 3,
  parameter int INIT        = 0,
  parameter int SKIP_IDLE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VC-1:0]          req_i,
  input  logic                   hold_i,
  input  logic                   cfg_load_i,
  input  logic [VC*WEIGHT_W-1:0] cfg_weight_i,
  output logic [VC:0]            sel_o,
  output logic [VC-1:0]          sel_onehot_o,
  output logic                   sel_valid_o,
  output logic                   slot_last_o
);
  localparam int IW = $clog2(VC);
  function automatic logic [VC*WEIGHT_W-1:0] def_w();
    logic [VC*WEIGHT_W-1:0] r;
    r = '0;
    for (int p = 0; p < VC; p++) r[p*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(default_weight(p, CRIT_WEIGHT));
    return r;
  endfunction
  localparam logic [VC*WEIGHT_W-1:0] W_DEF = def_w();
  localparam logic [WEIGHT_W-1:0] SLOT_INIT = W_DEF[INIT*WEIGHT_W +: WEIGHT_W];
  logic [IW-1:0]          cur_q, start, idx;
  logic [WEIGHT_W-1:0]    slot_q;
  logic [VC*WEIGHT_W-1:0] w_act_q, w_shd_q, w_eff;
  logic                   pend_q, found, adv;
  logic [VC-1:0]          elig, elig_eff;
  for (genvar p = 0; p < VC; p++) begin : g_elig
    assign elig[p]     = (w_act_q[p*WEIGHT_W +: WEIGHT_W] != '0) && ((SKIP_IDLE == 0) || req_i[p]);
    assign elig_eff[p] = (w_eff[p*WEIGHT_W +: WEIGHT_W] != '0) && ((SKIP_IDLE == 0) || req_i[p]);
  end
  assign w_eff = pend_q ? w_shd_q : w_act_q;
  assign start = (cur_q == IW'(VC - 1)) ? '0 : cur_q + 1'b1;
  assign adv   = (slot_q <= WEIGHT_W'(1)) || !elig[cur_q];
  vc_rr_search #(.N(VC), .IW(IW)) u_search (
    .elig_i  (elig_eff),
    .start_i (start),
    .found_o (found),
    .idx_o   (idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= IW'(INIT);
      slot_q  <= SLOT_INIT;
      w_act_q <= W_DEF;
      w_shd_q <= W_DEF;
      pend_q  <= 1'b0;
    end else begin
      if (cfg_load_i) begin
        w_shd_q <= cfg_weight_i;
        pend_q  <= 1'b1;
      end
      if (!hold_i && adv) begin
        cur_q  <= found ? idx : cur_q;
        slot_q <= found ? w_eff[int'(idx)*WEIGHT_W +: WEIGHT_W] : '0;
        // A load landing on this boundary keeps pend set and commits at the next one
        if (pend_q) begin
          w_act_q <= w_shd_q;
          pend_q  <= cfg_load_i;
        end
      end else if (!hold_i) begin
        slot_q <= slot_q - 1'b1;
      end
    end
  end
  assign sel_o        = {{(VC + 1 - IW){SEL_PAD}}, cur_q};
  assign sel_onehot_o = VC'(1) << cur_q;
  assign sel_valid_o  = elig[cur_q];
  assign slot_last_o  = (slot_q == WEIGHT_W'(1)) && !hold_i;
endmodule

// File: tb/tb_vc_plane_scheduler.sv
// tb_vc_plane_scheduler: directed vector and sequence checks for the VC plane scheduler
module tb_vc_plane_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req0 = 4'hf, req1 = 4'h0;
  logic        hold0 = 1'b0, hold1 = 1'b0, load0 = 1'b0, load1 = 1'b0;
  logic [15:0] w0 = '0, w1 = '0;
  logic [4:0]  sel0, sel1;
  logic [3:0]  oh0, oh1;
  logic        v0, v1, last0, last1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_plane_scheduler dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .hold_i(hold0), .cfg_load_i(load0), .cfg_weight_i(w0),
    .sel_o(sel0), .sel_onehot_o(oh0), .sel_valid_o(v0), .slot_last_o(last0)
  );
  vc_plane_scheduler #(.SKIP_IDLE(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .hold_i(hold1), .cfg_load_i(load1), .cfg_weight_i(w1),
    .sel_o(sel1), .sel_onehot_o(oh1), .sel_valid_o(v1), .slot_last_o(last1)
  );

  typedef struct {
    logic        ld;
    logic [15:0] w;
    int          sel;
    logic        v;
    logic        last;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic exp0(input string nm, input int s, input logic v, input logic l);
    chk({nm, ".sel"}, int'(sel0), s);
    chk({nm, ".onehot"}, int'(oh0), 1 << s);
    chk({nm, ".valid"}, int'(v0), int'(v));
    chk({nm, ".last"}, int'(last0), int'(l));
  endtask

  task automatic exp1(input string nm, input int s, input logic v);
    chk({nm, ".sel"}, int'(sel1), s);
    chk({nm, ".onehot"}, int'(oh1), 1 << s);
    chk({nm, ".valid"}, int'(v1), int'(v));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    tv[0] = '{1'b0, 16'h0000, 0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 16'h1201, 0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 16'h0000, 0, 1'b1, 1'b1};
    tv[3] = '{1'b0, 16'h0000, 2, 1'b1, 1'b0};
    tv[4] = '{1'b0, 16'h0000, 2, 1'b1, 1'b1};
    tv[5] = '{1'b0, 16'h0000, 3, 1'b1, 1'b1};
    tv[6] = '{1'b0, 16'h0000, 0, 1'b1, 1'b1};
    tv[7] = '{1'b0, 16'h0000, 2, 1'b1, 1'b0};
    tv[8] = '{1'b0, 16'h0000, 2, 1'b1, 1'b1};
    tv[9] = '{1'b0, 16'h0000, 3, 1'b1, 1'b1};

    step();
    step();
    exp0("reset", 0, 1'b1, 1'b0);
    do_reset();
    exp0("legacy.c1", 0, 1'b1, 1'b0); step();
    exp0("legacy.c2", 0, 1'b1, 1'b0); step();
    exp0("legacy.c3", 0, 1'b1, 1'b1); step();
    exp0("legacy.c4", 1, 1'b1, 1'b1); step();
    exp0("legacy.c5", 2, 1'b1, 1'b1); step();
    exp0("legacy.c6", 3, 1'b1, 1'b1); step();
    exp0("legacy.c7", 0, 1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      load0 = tv[i].ld;
      w0 = tv[i].w;
      #1;
      exp0($sformatf("cfg.v%0d", i), tv[i].sel, tv[i].v, tv[i].last);
      step();
      load0 = 1'b0;
    end

    do_reset();
    exp0("hold.c1", 0, 1'b1, 1'b0); step();
    for (int k = 0; k < 5; k++) begin
      hold0 = 1'b1;
      #1;
      exp0($sformatf("hold.h%0d", k), 0, 1'b1, 1'b0);
      step();
    end
    hold0 = 1'b0;
    #1;
    exp0("hold.rel1", 0, 1'b1, 1'b0); step();
    exp0("hold.rel2", 0, 1'b1, 1'b1); step();
    exp0("hold.p1", 1, 1'b1, 1'b1);
    load0 = 1'b1;
    w0 = 16'h0001;
    step();
    load0 = 1'b0;
    exp0("hold.p2", 2, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp0("rst.c1", 0, 1'b1, 1'b0); step();
    exp0("rst.c2", 0, 1'b1, 1'b0); step();
    exp0("rst.c3", 0, 1'b1, 1'b1); step();
    exp0("rst.c4", 1, 1'b1, 1'b1); step();
    exp0("rst.c5", 2, 1'b1, 1'b1);

    do_reset();
    load0 = 1'b1;
    w0 = 16'h0000;
    #1;
    exp0("zero.c1", 0, 1'b1, 1'b0); step();
    load0 = 1'b0;
    exp0("zero.c2", 0, 1'b1, 1'b0); step();
    exp0("zero.c3", 0, 1'b1, 1'b1); step();
    exp0("zero.c4", 0, 1'b0, 1'b0); step();
    load0 = 1'b1;
    w0 = 16'h4000;
    exp0("zero.c5", 0, 1'b0, 1'b0); step();
    load0 = 1'b0;
    exp0("zero.c6", 0, 1'b0, 1'b0); step();
    for (int k = 0; k < 8; k++) begin
      exp0($sformatf("p3.k%0d", k), 3, 1'b1, (k % 4) == 3);
      step();
    end

    req1 = 4'b0000;
    do_reset();
    exp1("skip.idle", 0, 1'b0);
    req1 = 4'b0100;
    #1;
    exp1("skip.req", 0, 1'b0); step();
    exp1("skip.t1", 2, 1'b1);
    chk("skip.t1.last", int'(last1), 1); step();
    exp1("skip.t2", 2, 1'b1); step();
    req1 = 4'b0000;
    #1;
    exp1("skip.drop", 2, 1'b0); step();
    exp1("skip.d1", 2, 1'b0);
    chk("skip.d1.last", int'(last1), 0); step();
    exp1("skip.d2", 2, 1'b0);

    req1 = 4'b0011;
    do_reset();
    exp1("fft.c1", 0, 1'b1);
    chk("fft.c1.last", int'(last1), 0); step();
    req1 = 4'b0010;
    #1;
    exp1("fft.drop", 0, 1'b0); step();
    exp1("fft.c3", 1, 1'b1); step();
    exp1("fft.c4", 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vc_plane_scheduler.md
# vc_plane_scheduler

Weighted, request-aware successor to the fixed round-robin VC plane selector. Time-multiplexes the router's shared CFSM/HFB/VCG/switch-control datapath across `VC` virtual-channel planes. Each plane gets a run-time programmable quantum of consecutive cycles. Idle planes can optionally be skipped. With default parameters and no configuration writes, it reproduces the legacy 3-1-1-1 critical-plane schedule.

## Interface
Parameters:
- `VC`, 4, number of VC planes (≥2).
- `WEIGHT_W`, 4, width of each per-plane quantum.
- `CRIT_WEIGHT`, 3, reset quantum of plane 0. Planes 1..VC-1 reset to 1.
- `INIT`, 0, plane selected out of reset.
- `SKIP_IDLE`, 0. 1 means planes with `req_i` low are ineligible and forfeit their remaining quantum.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_i`  in  VC  per-plane pending-work flag.
- `hold_i`  in  1  freezes the schedule (mid-packet lock).
- `cfg_load_i`  in  1  single-cycle pulse that writes `cfg_weight_i` into the shadow weight register.
- `cfg_weight_i`  in  VC*WEIGHT_W  per-plane quanta, plane p at bits [p*WEIGHT_W +: WEIGHT_W]. A quantum of 0 disables the plane.
- `sel_o`  out  VC+1  zero-extended binary index of the active plane. Same width as the legacy selector, so existing consumers are drop-in.
- `sel_onehot_o`  out  VC  one-hot form of `sel_o`.
- `sel_valid_o`  out  1  active plane is eligible this cycle.
- `slot_last_o`  out  1  current cycle is the last slot of the active quantum.

## Operation
- State:
  - `cur` (active plane).
  - `slot_cnt` (remaining slots, WEIGHT_W bits).
  - `w_act` (active weights), `w_shd` (shadow weights), `pend` (a shadow write is waiting to commit).
- Eligibility: `elig[p] = (w_act[p] != 0) && (!SKIP_IDLE || req_i[p])`.
- Each cycle, the first matching rule applies:
  1. `rst`: `cur = INIT`; `w_act = w_shd` = defaults; `pend = 0`; `slot_cnt = w_default[INIT]`.
  2. `hold_i`: `cur` and `slot_cnt` are unchanged.
  3. Advance condition: `slot_cnt <= 1`, or `!elig[cur]`. This covers forfeit, disable, and the SKIP_IDLE request drop.
     - On advance, search rotating from `cur+1` and wrap at VC-1 → 0. The search may wrap back to `cur` itself.
     - The search uses `w_eff = pend ? w_shd : w_act`.
     - First eligible plane n: `cur = n`, `slot_cnt = w_eff[n]`. If `pend`, commit `w_act = w_shd` and clear `pend`.
     - No plane eligible: `cur` is unchanged, `slot_cnt = 0`, and the search repeats every cycle.
  4. Otherwise decrement `slot_cnt`.
- `cfg_load_i`:
  - Writes `w_shd` and sets `pend` at the same edge.
  - Never alters the quantum in progress.
  - A load in a boundary cycle commits at the next boundary, not the current one.
  - `cfg_load_i` is honoured even while `hold_i` is high.
- Outputs:
  - `sel_valid_o = elig[cur]`. Combinational from `req_i` when SKIP_IDLE=1; 0 whenever no plane is eligible.
  - `slot_last_o = (slot_cnt == 1) && !hold_i`.
- Reset values: `sel_o = INIT`, `sel_onehot_o = 1<<INIT`, `sel_valid_o = 1` (SKIP_IDLE=0), `slot_last_o = (w_default[INIT] == 1)`.

## Timing
- `cur` and `slot_cnt` are registered, so `sel_o`/`sel_onehot_o` change only at clock edges. A plane switch is visible the cycle after the last slot.
- Request-to-select latency (SKIP_IDLE=1, scheduler idle) is 1 cycle: `req_i[p]` rises in cycle t, `sel_o = p` in t+1.
- A request drop on the active plane is reflected in `sel_valid_o` in the same cycle, and the plane is left at the next edge.
- `hold_i` takes effect at the edge it is sampled. Its release resumes with the remaining slots and no extra bubble.
- A weight-only update is never visible before the first boundary after `cfg_load_i`.

## Structure
- Package `vc_sched_pkg`:
  - `weight_t` (`logic [WEIGHT_W-1:0]`).
  - A default-weight function.
  - The `sel_o` padding constant.
- Sub-module `vc_rr_search`: combinational rotating priority finder. Inputs are eligibility vector and start index; outputs are `found` and `idx`. It is reused by the router arbiters.
- Top level: counter/FSM, shadow registers, output decode.

## Test plan
- Defaults, SKIP_IDLE=0, reset release → `sel_o` = 0,0,0,1,2,3,0,0,0,…; `slot_last_o` high on the 3rd, 4th, 5th and 6th cycles.
- `cfg_load_i` with {1,0,2,1} during the 2nd slot of plane 0 → plane 0 finishes 3 slots, then the sequence is 2,2,3,0,2,2,3,…; plane 1 is never selected.
- SKIP_IDLE=1, `req_i = 4'b0100` → `sel_o = 2` one cycle later and stays there with `sel_valid_o = 1`. Dropping `req_i[2]` gives `sel_valid_o = 0` immediately, `sel_o` stays 2 and the search repeats each cycle.
- SKIP_IDLE=1, plane 0 active with 2 slots left, `req_i[0]` falls → next cycle `sel_o` = next requesting plane; plane 0's remaining slots are forfeited.
- `hold_i` for 5 cycles in plane 0's 2nd slot → `sel_o = 0` throughout, `slot_last_o` is low while held, and 2 slots remain after release. Assert `rst` in the next plane-2 slot → next cycle `sel_o = 0`, `slot_cnt = 3`, defaults are restored and `pend` is cleared.
- Load all weights 0 → after the current quantum ends `sel_valid_o = 0` and `sel_o` is unchanged. Load {0,0,0,4} → plane 3 for 4 cycles, repeating.
